// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types, sizing helpers and Booth digit encodings for the fixed-point multiplier.
package fxp_pkg;
  typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;
  localparam logic [2:0] BW_P2A = 3'b011;
  localparam logic [2:0] BW_M2A = 3'b100;
  function automatic int mant_w(input int width, input int sf_bits);
    return width - sf_bits;
  endfunction
  function automatic int booth_iters(input int m);
    return (m + 1) / 2;
  endfunction
endpackage

// File: rtl/booth_r4_pp.sv
// booth_r4_pp: radix-4 Booth partial product (0, +-A, +-2A) for one 3-bit multiplier window.
module booth_r4_pp import fxp_pkg::*; #(
  parameter int P = 14
) (
  input  logic [2:0]   win,
  input  logic [P-1:0] mcand,
  output logic [P+1:0] pp
);
  logic [P+1:0] a1, a2, mag;
  logic one, two;
  always_comb begin
    a1 = (P+2)'($signed(mcand));
    a2 = {a1[P:0], 1'b0};
    one = win[1] ^ win[0];
    two = (win == BW_P2A) || (win == BW_M2A);
    mag = two ? a2 : one ? a1 : '0;
    pp = win[2] ? -mag : mag;
  end
endmodule

// File: rtl/fxp_mult_seq.sv
// fxp_mult_seq: sequential radix-4 Booth fixed-point multiplier with rescale and wrap/saturate.
module fxp_mult_seq import fxp_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int SF_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);
  localparam int M    = mant_w(WIDTH, SF_BITS);
  localparam int P    = M + (M % 2);
  localparam int ITER = booth_iters(M);
  localparam int A    = 2 * M;
  localparam int CW   = $clog2(ITER) + 1;

  state_t state, nxt;
  logic [SF_BITS-1:0] sa, sb, smax, smin;
  logic sat, bprev, ovf;
  logic [P-1:0] ma, mb;
  logic [A-1:0] acc, pp_ext, prod_s;
  logic [CW-1:0] cnt, idx;
  logic [P+1:0] pp;
  logic [M:0] hi;
  logic [M-1:0] mant;

  booth_r4_pp #(.P(P)) u_pp (.win({mb[1:0], bprev}), .mcand(ma), .pp(pp));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = in_valid ? MUL : IDLE;
      MUL:   nxt = (cnt == '0) ? SHIFT : MUL;
      SHIFT: nxt = DONE;
      DONE:  nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end

  // Digit i is retired when cnt == ITER-1-i, so its weight is 4^i.
  always_comb begin
    idx = CW'(ITER - 1) - cnt;
    pp_ext = A'($signed(pp)) << {idx, 1'b0};
    smax = (sa > sb) ? sa : sb;
    smin = (sa > sb) ? sb : sa;
    prod_s = $signed(acc) >>> smin;
    hi = prod_s[A-1:M-1];
    ovf = !((&hi) || (~|hi));
    mant = (sat && ovf) ? (prod_s[A-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}}) : prod_s[M-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      sat <= 1'b0;
      ma <= '0;
      mb <= '0;
      bprev <= 1'b0;
      acc <= '0;
      cnt <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sa <= op_a[WIDTH-1:M];
        sb <= op_b[WIDTH-1:M];
        sat <= sat_en;
        ma <= P'($signed(op_a[M-1:0]));
        mb <= P'($signed(op_b[M-1:0]));
        bprev <= 1'b0;
        acc <= '0;
        cnt <= CW'(ITER - 1);
      end
      if (state == MUL) begin
        acc <= acc + pp_ext;
        mb <= {{2{mb[P-1]}}, mb[P-1:2]};
        bprev <= mb[1];
        cnt <= cnt - 1'b1;
      end
      if (state == SHIFT) begin
        out_data <= {smax, mant};
        overflow <= ovf;
      end
    end
endmodule

// File: tb/tb_fxp_mult_seq.sv
// tb_fxp_mult_seq: scoreboard bench with directed spec cases and a randomized run against an integer model.
module tb_fxp_mult_seq;
  localparam int W = 16, SF = 3, M = 13, ITER = 7;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sat_en = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, overflow;
  logic [W-1:0] op_a = '0, op_b = '0, out_data;
  int n_cmp = 0, n_bad = 0, cyc = 0, hs_cyc = 0;
  logic [W:0] sb_q[$];
  logic [W:0] mon_exp;
  bit rnd_rdy = 1'b0, prev_v = 1'b0;

  fxp_mult_seq #(.WIDTH(W), .SF_BITS(SF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, arithmetic rescale, range test on M signed bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint pa = longint'($signed(a[M-1:0]));
    longint pb = longint'($signed(b[M-1:0]));
    int scl_a = int'(a[W-1:M]);
    int scl_b = int'(b[W-1:M]);
    int sh = (scl_a < scl_b) ? scl_a : scl_b;
    int so = (scl_a < scl_b) ? scl_b : scl_a;
    longint ps = (pa * pb) >>> sh;
    longint lim = longint'(1) << (M - 1);
    logic ov = (ps >= lim) || (ps < -lim);
    logic [63:0] pv = ps;
    logic [M-1:0] mt = (s && ov) ? ((ps < 0) ? M'(-lim) : M'(lim - 1)) : pv[M-1:0];
    return {ov, SF'(so), mt};
  endfunction

  always @(negedge clk)
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (in_valid && in_ready) hs_cyc = cyc;
      if (out_valid && !prev_v) check("latency", cyc - hs_cyc, ITER + 2);
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_out", sb_q.size(), 1);
        else begin
          mon_exp = sb_q.pop_front();
          check("out_data", out_data, mon_exp[W-1:0]);
          check("overflow", overflow, mon_exp[W]);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    op_a = a;
    op_b = b;
    sat_en = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    sat_en = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  task automatic push_send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [W:0] e);
    sb_q.push_back(e);
    send(a, b, s);
  endtask

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    logic rs;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push_send(16'h0003, 16'h0005, 1'b0, {1'b0, 16'h000F});
    push_send(16'h4064, 16'hBFFC, 1'b0, {1'b0, 16'hBF9C});
    push_send(16'h0FFF, 16'h0FFF, 1'b0, {1'b1, 16'h0001});
    push_send(16'h0FFF, 16'h0FFF, 1'b1, {1'b1, 16'h0FFF});
    push_send(16'h0FFF, 16'h1000, 1'b1, {1'b1, 16'h1000});
    drain();
    out_ready = 1'b0;
    push_send(16'h4064, 16'hBFFC, 1'b0, {1'b0, 16'hBF9C});
    t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    check("bp_valid", out_valid, 1);
    repeat (5) begin
      in_valid = 1'b1;
      op_a = W'($urandom);
      op_b = W'($urandom);
      tick();
      check("bp_hold_data", out_data, 16'hBF9C);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid_hold", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
    send(16'h0003, 16'h0005, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    push_send(16'h2003, 16'h4005, 1'b0, {1'b0, 16'h4007});
    drain();
    rnd_rdy = 1'b1;
    repeat (60) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ra[M-1:M-6] = {6{ra[M-1]}};
      push_send(ra, rb, rs, model(ra, rb, rs));
    end
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fxp_mult_seq.md
# fxp_mult_seq

Parametrised, sequential fixed-point multiplier for the ODE solver datapath. Operands use the team's scaled fixed-point word: `{scale, mantissa}`, where the mantissa is two's complement. The block multiplies the mantissas with an iterative radix-4 Booth engine, rescales the product, and flags or saturates overflow. It replaces the single-cycle combinational 16-bit multiplier with a valid/ready streaming unit sized by parameter.

## Interface
Parameters:
- `WIDTH`, 16: total word width, including the scale field.
- `SF_BITS`, 3: scale-field width. The mantissa width is `M = WIDTH - SF_BITS`. Legal range: `1 <= SF_BITS <= WIDTH-4`.

Ports:
- `clk`  in  1  — the single clock. All state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — operand pair present.
- `in_ready`  out  1  — block can accept an operand pair.
- `op_a`  in  WIDTH  — first operand, `{scale_a[SF_BITS-1:0], mant_a[M-1:0]}`.
- `op_b`  in  WIDTH  — second operand, same format.
- `sat_en`  in  1  — selects saturate (1) or wrap (0). Sampled with the operands.
- `out_valid`  out  1  — result present.
- `out_ready`  in  1  — downstream accepts the result.
- `out_data`  out  WIDTH  — result, `{scale_o, mant_o}`.
- `overflow`  out  1  — the rescaled product did not fit in M signed bits. Valid only with `out_valid`.

## Operation
- FSM states: IDLE, MUL, SHIFT, DONE.
- Reset (async, `rst_n` = 0):
  - state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `overflow` = 0.
  - All internal registers are cleared.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `scale_a`, `scale_b` and `sat_en`.
  - Sign-extend both mantissas to `P = M + (M odd)` bits and clear the 2M-bit accumulator.
  - Load iteration counter = `ITER - 1`, where `ITER = ceil(M/2)`. Go to MUL.
- **MUL**
  - Each cycle, retire one radix-4 Booth digit (multiplier bits `{b[2i+1], b[2i], b[2i-1]}`, with `b[-1] = 0`).
  - Add the partial product 0, ±A or ±2A, shifted by 2i, into the accumulator.
  - When the counter reaches 0, go to SHIFT.
- **SHIFT**
  - `scale_o = max(scale_a, scale_b)` and `sh = min(scale_a, scale_b)`. On a tie, both equal that scale.
  - `prod_s = acc >>> sh` (arithmetic shift, 2M bits wide).
  - `overflow` = 1 unless `prod_s[2M-1:M-1]` is all zeros or all ones.
  - Mantissa:
    - `sat_en` = 0: `mant_o = prod_s[M-1:0]` (wrap).
    - `sat_en` = 1 and overflow: `mant_o` = `2^(M-1) - 1` if `prod_s` is non-negative, otherwise `-2^(M-1)`.
  - Register `out_data` and `overflow`. Go to DONE.
- **DONE**
  - `out_valid` = 1.
  - Hold `out_data` and `overflow` stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- Only one transaction is in flight at a time. `in_ready` is 1 only in IDLE.
- `op_a`, `op_b` and `sat_en` are ignored outside the accept cycle.
- Zero operands take no fast path; latency is fixed.

## Timing
- If the input handshake occurs at rising edge `k`, `out_valid` rises after edge `k + ITER + 1`.
- Latency = `ITER + 2` edges. For WIDTH=16, SF_BITS=3: M=13, ITER=7, latency 9.
- Throughput: at most one result per `ITER + 3` cycles. The return to IDLE costs one cycle after the output handshake.
- Outputs are registered. No combinational path from `in_valid` or `out_ready` to any output.
- `out_ready` held high before DONE: the result is accepted in the first DONE cycle.
- Reset asserted mid-MUL, SHIFT or DONE aborts the transaction. No result is emitted. Reset values apply immediately.

## Structure
- Package `fxp_pkg`:
  - state enum (IDLE/MUL/SHIFT/DONE);
  - functions `mant_w(WIDTH, SF_BITS)` and `booth_iters(M)`;
  - Booth digit encoding constants.
- Sub-module `booth_r4_pp`:
  - purely combinational;
  - takes the 3-bit multiplier window and the P-bit multiplicand;
  - returns the sign-extended (P+2)-bit partial product.
- The FSM, shifter and saturation logic live in `fxp_mult_seq`.

## Test plan
All scenarios use WIDTH=16, SF_BITS=3.
- Basic: `op_a` = 0x0003, `op_b` = 0x0005, `sat_en` = 0 -> after 9 cycles `out_data` = 0x000F, `overflow` = 0.
- Rescale, signed: `op_a` = 0x4064 (s2, +100), `op_b` = 0xBFFC (s5, -4) -> `out_data` = 0xBF9C (s5, -100), `overflow` = 0.
- Wrap overflow: `op_a` = `op_b` = 0x0FFF, `sat_en` = 0 -> `out_data` = 0x0001, `overflow` = 1.
- Saturate: same operands, `sat_en` = 1 -> `out_data` = 0x0FFF, `overflow` = 1. With `op_b` = 0x1000 (-4096) -> `out_data` = 0x1000, `overflow` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE -> `out_data` stable, `in_ready` = 0, `in_valid` ignored. Then release -> IDLE on the next edge.
- Reset mid-MUL: drop `rst_n` at cycle 3 of MUL -> `out_valid` = 0 and `out_data` = 0 asynchronously. `in_ready` = 1 after release. A following transaction gives the correct result.
